// File: rtl/nv_stream_demux2.sv
// 1-to-2 valid/ready packet demux; destination locked on a packet's first beat, order kept across ports.
// Latency: one cycle from input acceptance to output valid; sustains one beat per clock.
// Backpressure: two-entry main/skid pipe; in_ready is the registered "skid empty" flag, so no comb path.
module nv_stream_demux2 #(
    parameter int DW = 32
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pd,
    input  logic          in_sel,
    input  logic          in_last,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_pd,
    output logic          out0_last,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_pd,
    output logic          out1_last,
    output logic          pkt_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] pd;
        logic          last;
        logic          dst;
    } slot_t;

    state_t state_q, state_d;
    slot_t  main_q, main_d;
    slot_t  skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;

    logic   acc;
    logic   pop;
    logic   route;
    slot_t  in_beat;

    assign in_ready = !skid_vld_q;
    assign acc      = in_valid & in_ready;
    assign pop      = main_vld_q & (main_q.dst ? out1_ready : out0_ready);

    // Route is only taken from in_sel on a first beat; inside a packet it is the locked port.
    always_comb begin
        route = in_sel;
        case (state_q)
            PKT0:    route = 1'b0;
            PKT1:    route = 1'b1;
            default: route = in_sel;
        endcase
    end

    assign in_beat = '{pd: in_pd, last: in_last, dst: route};

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d = in_sel ? PKT1 : PKT0;
                    end
                end
                PKT0, PKT1: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // acc already implies the skid is empty, so a skid refill and a skid drain never coincide.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (pop) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end

        if (acc) begin
            if (!main_vld_q || pop) begin
                main_d     = in_beat;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out0_valid = main_vld_q & ~main_q.dst;
    assign out1_valid = main_vld_q &  main_q.dst;
    assign out0_pd    = main_q.pd;
    assign out1_pd    = main_q.pd;
    assign out0_last  = main_q.last;
    assign out1_last  = main_q.last;
    assign pkt_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_nv_stream_demux2.sv
// Bench for nv_stream_demux2: vector table, directed corner sequences, and a queue-model random soak.
module tb_nv_stream_demux2;

    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pd;
    logic          in_sel;
    logic          in_last;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_pd;
    logic          out0_last;
    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_pd;
    logic          out1_last;
    logic          pkt_busy;

    nv_stream_demux2 #(.DW(DW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pd          (in_pd),
        .in_sel         (in_sel),
        .in_last        (in_last),
        .out0_valid     (out0_valid),
        .out0_ready     (out0_ready),
        .out0_pd        (out0_pd),
        .out0_last      (out0_last),
        .out1_valid     (out1_valid),
        .out1_ready     (out1_ready),
        .out1_pd        (out1_pd),
        .out1_last      (out1_last),
        .pkt_busy       (pkt_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (from a negedge) and return at the following negedge.
    task automatic tick(input logic v, input logic s, input logic l, input logic [31:0] pd,
                        input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_last    = l;
        in_pd      = pd;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
    endtask

    typedef struct {
        logic        v, sel, last;
        logic [31:0] pd;
        logic        r0, r1;
        logic        e_o0v, e_o1v, e_last, e_rdy, e_busy;
        logic [31:0] e_pd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic s, input logic l, input logic [31:0] pd,
                                input logic o0v, input logic o1v, input logic [31:0] epd,
                                input logic elast, input logic erdy, input logic ebusy);
        vec_t t;
        t.v = v; t.sel = s; t.last = l; t.pd = pd; t.r0 = 1'b1; t.r1 = 1'b1;
        t.e_o0v = o0v; t.e_o1v = o1v; t.e_pd = epd; t.e_last = elast;
        t.e_rdy = erdy; t.e_busy = ebusy;
        return t;
    endfunction

    typedef struct {
        logic [31:0] pd;
        logic        last;
        logic        dst;
    } beat_t;

    beat_t q[$];
    vec_t  tbl[10];

    initial begin
        in_valid = 0; in_sel = 0; in_last = 0; in_pd = '0;
        out0_ready = 0; out1_ready = 0;
        rstn = 1'b0;

        // Expected outputs are those seen after the clock edge that consumed the vector.
        tbl[0] = mk(1, 0, 1, 32'h1,  1, 0, 32'h1,  1, 1, 0);
        tbl[1] = mk(1, 1, 1, 32'h2,  0, 1, 32'h2,  1, 1, 0);
        tbl[2] = mk(1, 0, 1, 32'h3,  1, 0, 32'h3,  1, 1, 0);
        tbl[3] = mk(1, 1, 1, 32'h4,  0, 1, 32'h4,  1, 1, 0);
        tbl[4] = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0);
        tbl[5] = mk(1, 0, 0, 32'hA0, 1, 0, 32'hA0, 0, 1, 1);
        tbl[6] = mk(1, 1, 0, 32'hA1, 1, 0, 32'hA1, 0, 1, 1);
        tbl[7] = mk(1, 0, 0, 32'hA2, 1, 0, 32'hA2, 0, 1, 1);
        tbl[8] = mk(1, 1, 1, 32'hA3, 1, 0, 32'hA3, 1, 1, 0);
        tbl[9] = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0);

        // Reset state
        @(negedge clk);
        chk1("rst_out0_valid", out0_valid, 1'b0);
        chk1("rst_out1_valid", out1_valid, 1'b0);
        chk32("rst_out0_pd", out0_pd, 32'h0);
        chk1("rst_out1_last", out1_last, 1'b0);
        chk1("rst_pkt_busy", pkt_busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        rstn = 1'b1;
        @(negedge clk);

        // T3 back-to-back singles, T2 packet lock
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].v, tbl[i].sel, tbl[i].last, tbl[i].pd, tbl[i].r0, tbl[i].r1);
            chk1($sformatf("vec%0d_out0_valid", i), out0_valid, tbl[i].e_o0v);
            chk1($sformatf("vec%0d_out1_valid", i), out1_valid, tbl[i].e_o1v);
            chk1($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk1($sformatf("vec%0d_pkt_busy", i), pkt_busy, tbl[i].e_busy);
            if (tbl[i].e_o0v) begin
                chk32($sformatf("vec%0d_out0_pd", i), out0_pd, tbl[i].e_pd);
                chk1($sformatf("vec%0d_out0_last", i), out0_last, tbl[i].e_last);
            end
            if (tbl[i].e_o1v) begin
                chk32($sformatf("vec%0d_out1_pd", i), out1_pd, tbl[i].e_pd);
                chk1($sformatf("vec%0d_out1_last", i), out1_last, tbl[i].e_last);
            end
        end

        // T4 backpressure: three beats to a stalled out0
        tick(1, 0, 1, 32'h31, 0, 1);
        chk1("bp_rdy_after1", in_ready, 1'b1);
        chk32("bp_head1", out0_pd, 32'h31);
        tick(1, 0, 1, 32'h32, 0, 1);
        chk1("bp_rdy_after2", in_ready, 1'b0);
        chk32("bp_head_hold", out0_pd, 32'h31);
        tick(1, 0, 1, 32'h33, 0, 1);
        chk1("bp_rdy_full", in_ready, 1'b0);
        chk1("bp_valid_held", out0_valid, 1'b1);
        chk32("bp_head_still", out0_pd, 32'h31);
        tick(1, 0, 1, 32'h33, 1, 1);
        chk32("bp_drain2", out0_pd, 32'h32);
        chk1("bp_rdy_back", in_ready, 1'b1);
        tick(1, 0, 1, 32'h33, 1, 1);
        chk32("bp_drain3", out0_pd, 32'h33);
        chk1("bp_valid3", out0_valid, 1'b1);
        tick(0, 0, 0, 32'h0, 1, 1);
        chk1("bp_empty", out0_valid, 1'b0);

        // T5 head-of-line: Y for out1 must wait behind stalled X for out0
        tick(1, 0, 1, 32'h51, 0, 1);
        tick(1, 1, 1, 32'h52, 0, 1);
        chk1("hol_x_valid", out0_valid, 1'b1);
        chk1("hol_y_blocked", out1_valid, 1'b0);
        tick(0, 0, 0, 32'h0, 0, 1);
        chk1("hol_y_still_blocked", out1_valid, 1'b0);
        chk32("hol_x_pd", out0_pd, 32'h51);
        tick(0, 0, 0, 32'h0, 1, 1);
        chk1("hol_x_gone", out0_valid, 1'b0);
        chk1("hol_y_valid", out1_valid, 1'b1);
        chk32("hol_y_pd", out1_pd, 32'h52);
        tick(0, 0, 0, 32'h0, 1, 1);
        chk1("hol_drained", out1_valid, 1'b0);

        // T1 reset mid-packet with both slots full
        tick(1, 0, 0, 32'h61, 0, 0);
        tick(1, 0, 0, 32'h62, 0, 0);
        chk1("t1_pre_full", in_ready, 1'b0);
        chk1("t1_pre_busy", pkt_busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("t1_out0_valid", out0_valid, 1'b0);
        chk1("t1_out1_valid", out1_valid, 1'b0);
        chk1("t1_pkt_busy", pkt_busy, 1'b0);
        chk1("t1_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        tick(1, 1, 1, 32'h11, 1, 1);
        chk1("t1_post_out1_valid", out1_valid, 1'b1);
        chk32("t1_post_out1_pd", out1_pd, 32'h11);
        chk1("t1_post_out1_last", out1_last, 1'b1);
        chk1("t1_post_out0_valid", out0_valid, 1'b0);
        tick(0, 0, 0, 32'h0, 1, 1);
        chk1("t1_drained", out1_valid, 1'b0);

        // T6 random soak against an in-order, capacity-2 queue model
        begin
            int    acc_cnt = 0;
            int    dlv_cnt = 0;
            int    cyc     = 0;
            logic  open    = 1'b0;
            logic  pkt_dst = 1'b0;
            logic  v, s, l, r0, r1, acc, pop, dst;
            logic [31:0] pd;
            q.delete();
            while ((acc_cnt < 10000 || q.size() != 0) && cyc < 60000) begin
                if (q.size() > 0) begin
                    chk1("soak_out0_valid", out0_valid, ~q[0].dst);
                    chk1("soak_out1_valid", out1_valid, q[0].dst);
                    chk32("soak_pd", q[0].dst ? out1_pd : out0_pd, q[0].pd);
                    chk1("soak_last", q[0].dst ? out1_last : out0_last, q[0].last);
                end else begin
                    chk1("soak_idle_out0", out0_valid, 1'b0);
                    chk1("soak_idle_out1", out1_valid, 1'b0);
                end
                chk1("soak_in_ready", in_ready, q.size() < 2);
                chk1("soak_pkt_busy", pkt_busy, open);

                v  = (acc_cnt < 10000) && ($urandom_range(0, 3) != 0);
                s  = 1'($urandom_range(0, 1));
                l  = ($urandom_range(0, 2) == 0);
                pd = $urandom;
                r0 = ($urandom_range(0, 3) != 0);
                r1 = ($urandom_range(0, 3) != 0);

                acc = v && (q.size() < 2);
                pop = (q.size() > 0) && (q[0].dst ? r1 : r0);
                dst = open ? pkt_dst : s;
                if (pop) begin
                    void'(q.pop_front());
                    dlv_cnt++;
                end
                if (acc) begin
                    q.push_back('{pd: pd, last: l, dst: dst});
                    acc_cnt++;
                    open    = !l;
                    pkt_dst = dst;
                end
                tick(v, s, l, pd, r0, r1);
                cyc++;
            end
            chk1("soak_completed", (acc_cnt >= 10000) && (q.size() == 0), 1'b1);
            chk32("soak_delivered", 32'(dlv_cnt), 32'(acc_cnt));
            chk1("soak_end_out0_valid", out0_valid, 1'b0);
            chk1("soak_end_out1_valid", out1_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
